// File: rtl/dispatch_pkg.sv
// Shared types and the combinational decode for the dispatch decoder.
package dispatch_pkg;

    typedef enum logic [3:0] {
        OP_R     = 4'd1,
        OP_I     = 4'd2,
        OP_S     = 4'd3,
        OP_B     = 4'd4,
        OP_LUI   = 4'd5,
        OP_JAL   = 4'd6,
        OP_AUIPC = 4'd7,
        OP_JALR  = 4'd8,
        OP_LOAD  = 4'd9
    } opcode_e;

    typedef enum logic [1:0] {
        ST_ALU    = 2'd0,
        ST_BRANCH = 2'd1,
        ST_LSU    = 2'd2,
        ST_UPPER  = 2'd3
    } station_e;

    localparam logic [2:0] IMM_I    = 3'b000;
    localparam logic [2:0] IMM_S    = 3'b001;
    localparam logic [2:0] IMM_B    = 3'b010;
    localparam logic [2:0] IMM_U    = 3'b011;
    localparam logic [2:0] IMM_J    = 3'b100;
    localparam logic [2:0] IMM_NONE = 3'b111;

    localparam logic [1:0] ALU_INT    = 2'b00;
    localparam logic [1:0] ALU_BRANCH = 2'b01;
    localparam logic [1:0] ALU_ADDR   = 2'b10;
    localparam logic [1:0] ALU_NONE   = 2'b11;

    typedef struct packed {
        logic [2:0] imm_src;
        logic [1:0] alu_op;
        station_e   station;
        logic       mem_write;
        logic       is_load;
        logic       branch;
        logic       is_jal;
        logic       is_jalr;
        logic       is_lui;
        logic       is_auipc;
        logic       use_imm;
        logic       reg_write;
        logic       station_request;
        logic       rob_write;
    } bundle_t;

    function automatic logic is_legal(input logic [3:0] opcode);
        return (opcode >= 4'd1) && (opcode <= 4'd9);
    endfunction

    // Start from the common defaults and override per opcode; illegal opcodes yield all zeros.
    function automatic bundle_t decode(input logic [3:0] opcode, input logic [4:0] dest_reg);
        bundle_t b;
        b                 = '0;
        b.imm_src         = IMM_NONE;
        b.alu_op          = ALU_INT;
        b.station         = ST_ALU;
        b.use_imm         = 1'b1;
        b.reg_write       = (dest_reg != 5'd0);
        b.station_request = 1'b1;
        b.rob_write       = 1'b1;
        case (opcode)
            OP_R: begin
                b.imm_src = IMM_NONE;
                b.use_imm = 1'b0;
            end
            OP_I: b.imm_src = IMM_I;
            OP_S: begin
                b.station   = ST_LSU;
                b.imm_src   = IMM_S;
                b.alu_op    = ALU_ADDR;
                b.mem_write = 1'b1;
                b.reg_write = 1'b0;
            end
            OP_B: begin
                b.station   = ST_BRANCH;
                b.imm_src   = IMM_B;
                b.alu_op    = ALU_BRANCH;
                b.branch    = 1'b1;
                b.use_imm   = 1'b0;
                b.reg_write = 1'b0;
            end
            OP_LUI: begin
                b.station = ST_UPPER;
                b.imm_src = IMM_U;
                b.is_lui  = 1'b1;
            end
            // JAL resolves without a reservation station, so it carries no station credit.
            OP_JAL: begin
                b.station         = ST_BRANCH;
                b.imm_src         = IMM_J;
                b.alu_op          = ALU_NONE;
                b.is_jal          = 1'b1;
                b.station_request = 1'b0;
            end
            OP_AUIPC: begin
                b.station  = ST_UPPER;
                b.imm_src  = IMM_U;
                b.is_auipc = 1'b1;
            end
            OP_JALR: begin
                b.station = ST_BRANCH;
                b.imm_src = IMM_I;
                b.alu_op  = ALU_BRANCH;
                b.is_jalr = 1'b1;
            end
            OP_LOAD: begin
                b.station = ST_LSU;
                b.imm_src = IMM_I;
                b.alu_op  = ALU_ADDR;
                b.is_load = 1'b1;
            end
            default: b = '0;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/dispatch_decoder_if.sv
// Upstream instruction handshake and downstream decoded-bundle handshake.
interface dispatch_decoder_if #(
    parameter int NUM_STATIONS = 4
);
    localparam int SW = $clog2(NUM_STATIONS);

    logic          in_valid;
    logic          in_ready;
    logic [3:0]    opcode;
    logic [4:0]    dest_reg;
    logic          out_valid;
    logic          out_ready;
    logic [2:0]    imm_src;
    logic [1:0]    alu_op;
    logic [SW-1:0] rs_station;
    logic          mem_write;
    logic          is_load;
    logic          branch;
    logic          is_jal;
    logic          is_jalr;
    logic          is_lui;
    logic          is_auipc;
    logic          use_imm;
    logic          reg_write;
    logic          station_request;
    logic          rob_write;

    modport master (
        output in_valid, opcode, dest_reg, out_ready,
        input  in_ready, out_valid, imm_src, alu_op, rs_station, mem_write, is_load,
               branch, is_jal, is_jalr, is_lui, is_auipc, use_imm, reg_write,
               station_request, rob_write
    );

    modport slave (
        input  in_valid, opcode, dest_reg, out_ready,
        output in_ready, out_valid, imm_src, alu_op, rs_station, mem_write, is_load,
               branch, is_jal, is_jalr, is_lui, is_auipc, use_imm, reg_write,
               station_request, rob_write
    );
endinterface

// File: rtl/dispatch_decoder_credit_counter.sv
// Free-entry counter for one downstream resource; starts full, restore refills it.
module credit_counter #(
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       consume,
    input  logic                       free,
    input  logic                       restore,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [CW-1:0] count_reg;

    // Consume and free in the same cycle cancel; a free while already full is dropped.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_reg <= FULL;
        end else if (restore) begin
            count_reg <= FULL;
        end else if (consume && !free) begin
            count_reg <= count_reg - CW'(1);
        end else if (!consume && free && (count_reg != FULL)) begin
            count_reg <= count_reg + CW'(1);
        end
    end

    assign count = count_reg;
    assign empty = (count_reg == '0);

    // A returned credit with nothing outstanding means upstream accounting is broken.
    assert property (@(posedge clk) disable iff (!reset_n)
        !(free && !restore && (count_reg == FULL)));

endmodule

// File: rtl/dispatch_decoder.sv
// Registered, credit-aware decode stage between predecode and rename/ROB allocation.
module dispatch_decoder
    import dispatch_pkg::*;
#(
    parameter int NUM_STATIONS  = 4,
    parameter int STATION_DEPTH = 8,
    parameter int ROB_DEPTH     = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    dispatch_decoder_if.slave       bus,
    input  logic [NUM_STATIONS-1:0] station_free,
    input  logic                    rob_free,
    input  logic                    flush,
    output logic                    illegal,
    output logic [NUM_STATIONS-1:0] station_full,
    output logic                    rob_full
);
    localparam int SW  = $clog2(NUM_STATIONS);
    localparam int SCW = $clog2(STATION_DEPTH + 1);
    localparam int RCW = $clog2(ROB_DEPTH + 1);

    bundle_t        dec;
    logic           dec_legal;
    bundle_t        out_reg;
    logic           out_valid_reg;
    logic           illegal_reg;
    logic [SCW-1:0] station_count [NUM_STATIONS];
    logic [RCW-1:0] rob_count;
    logic           station_ok;
    logic           rob_ok;
    logic           ready;
    logic           accept;

    assign dec       = decode(bus.opcode, bus.dest_reg);
    assign dec_legal = is_legal(bus.opcode);

    // Ready depends only on the opcode, the output stage and the credits, never on in_valid.
    always_comb begin
        station_ok = 1'b1;
        rob_ok     = 1'b1;
        if (dec.station_request) begin
            station_ok = (station_count[dec.station] != '0);
        end
        if (dec_legal) begin
            rob_ok = (rob_count != '0);
        end
        ready = (!out_valid_reg || bus.out_ready) && !flush && station_ok && rob_ok;
    end

    assign accept       = bus.in_valid && ready;
    assign bus.in_ready = ready;

    // Output stage: load on a legal accept, drop on pop or flush, hold while stalled.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_reg       <= '0;
            out_valid_reg <= 1'b0;
            illegal_reg   <= 1'b0;
        end else begin
            illegal_reg <= accept && !dec_legal;
            if (flush) begin
                out_valid_reg <= 1'b0;
            end else if (accept && dec_legal) begin
                out_valid_reg <= 1'b1;
                out_reg       <= dec;
            end else if (bus.out_ready) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_STATIONS; gi++) begin : g_station
            credit_counter #(
                .DEPTH (STATION_DEPTH)
            ) u_credit (
                .clk     (clk),
                .reset_n (reset_n),
                .consume (accept && dec.station_request && (32'(dec.station) == gi)),
                .free    (station_free[gi]),
                .restore (flush),
                .count   (station_count[gi]),
                .empty   (station_full[gi])
            );
        end
    endgenerate

    credit_counter #(
        .DEPTH (ROB_DEPTH)
    ) u_rob_credit (
        .clk     (clk),
        .reset_n (reset_n),
        .consume (accept && dec_legal),
        .free    (rob_free),
        .restore (flush),
        .count   (rob_count),
        .empty   (rob_full)
    );

    assign illegal             = illegal_reg;
    assign bus.out_valid       = out_valid_reg;
    assign bus.imm_src         = out_reg.imm_src;
    assign bus.alu_op          = out_reg.alu_op;
    assign bus.rs_station      = SW'(out_reg.station);
    assign bus.mem_write       = out_reg.mem_write;
    assign bus.is_load         = out_reg.is_load;
    assign bus.branch          = out_reg.branch;
    assign bus.is_jal          = out_reg.is_jal;
    assign bus.is_jalr         = out_reg.is_jalr;
    assign bus.is_lui          = out_reg.is_lui;
    assign bus.is_auipc        = out_reg.is_auipc;
    assign bus.use_imm         = out_reg.use_imm;
    assign bus.reg_write       = out_reg.reg_write;
    assign bus.station_request = out_reg.station_request;
    assign bus.rob_write       = out_reg.rob_write;

endmodule

// File: tb/tb_dispatch_decoder.sv
// Scenario tasks plus a randomized run against a table-driven reference model.
module tb_dispatch_decoder;
    localparam int NS = 4;
    localparam int SD = 8;
    localparam int RD = 16;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [NS-1:0] station_free;
    logic          rob_free;
    logic          flush;
    logic          illegal;
    logic [NS-1:0] station_full;
    logic          rob_full;

    dispatch_decoder_if #(.NUM_STATIONS(NS)) bus();

    dispatch_decoder #(
        .NUM_STATIONS  (NS),
        .STATION_DEPTH (SD),
        .ROB_DEPTH     (RD)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .bus          (bus),
        .station_free (station_free),
        .rob_free     (rob_free),
        .flush        (flush),
        .illegal      (illegal),
        .station_full (station_full),
        .rob_full     (rob_full)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    int          cred [NS];
    int          rob;
    bit          m_valid;
    logic [17:0] m_bundle;
    bit          m_illegal;

    function automatic bit ref_legal(input logic [3:0] op);
        return (op >= 4'd1) && (op <= 4'd9);
    endfunction

    function automatic int ref_station(input logic [3:0] op);
        case (op)
            4'd1, 4'd2:       return 0;
            4'd4, 4'd6, 4'd8: return 1;
            4'd3, 4'd9:       return 2;
            4'd5, 4'd7:       return 3;
            default:          return 0;
        endcase
    endfunction

    function automatic bit ref_needs_station(input logic [3:0] op);
        return ref_legal(op) && (op != 4'd6);
    endfunction

    // Layout: imm_src, alu_op, rs_station, then the eleven flags in port order.
    function automatic logic [17:0] ref_bundle(input logic [3:0] op, input logic [4:0] rd);
        logic [2:0] imm;
        logic [1:0] alu;
        logic [1:0] st;
        case (op)
            4'd1:             imm = 3'b111;
            4'd3:             imm = 3'b001;
            4'd4:             imm = 3'b010;
            4'd5, 4'd7:       imm = 3'b011;
            4'd6:             imm = 3'b100;
            default:          imm = 3'b000;
        endcase
        case (op)
            4'd3, 4'd9: alu = 2'b10;
            4'd4, 4'd8: alu = 2'b01;
            4'd6:       alu = 2'b11;
            default:    alu = 2'b00;
        endcase
        st = 2'(ref_station(op));
        return {imm, alu, st,
                op == 4'd3, op == 4'd9, op == 4'd4, op == 4'd6, op == 4'd8, op == 4'd5, op == 4'd7,
                (imm != 3'b111) && (op != 4'd4),
                (rd != 5'd0) && (op != 4'd3) && (op != 4'd4),
                op != 4'd6,
                1'b1};
    endfunction

    function automatic logic [17:0] dut_bundle();
        return {bus.imm_src, bus.alu_op, bus.rs_station, bus.mem_write, bus.is_load, bus.branch,
                bus.is_jal, bus.is_jalr, bus.is_lui, bus.is_auipc, bus.use_imm, bus.reg_write,
                bus.station_request, bus.rob_write};
    endfunction

    function automatic bit exp_ready();
        bit ok;
        ok = (!m_valid || bus.out_ready) && !flush;
        if (ref_needs_station(bus.opcode) && cred[ref_station(bus.opcode)] == 0) ok = 0;
        if (ref_legal(bus.opcode) && rob == 0) ok = 0;
        return ok;
    endfunction

    function automatic logic [NS-1:0] exp_full();
        logic [NS-1:0] f;
        for (int i = 0; i < NS; i++) f[i] = (cred[i] == 0);
        return f;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NS; i++) cred[i] = SD;
        rob       = RD;
        m_valid   = 0;
        m_illegal = 0;
        m_bundle  = '0;
    endtask

    // Advance one clock, updating the model from the inputs currently applied.
    task automatic tick();
        bit         acc;
        logic [3:0] op;
        logic [4:0] rd;
        bit         rdy_out;
        logic [NS-1:0] sf;
        bit         rf;
        bit         fl;
        acc     = bus.in_valid && exp_ready();
        op      = bus.opcode;
        rd      = bus.dest_reg;
        rdy_out = bus.out_ready;
        sf      = station_free;
        rf      = rob_free;
        fl      = flush;
        @(posedge clk);
        if (acc) $display("txn: accept op=%0d rd=%0d legal=%0b", op, rd, ref_legal(op));
        if (fl) begin
            for (int i = 0; i < NS; i++) cred[i] = SD;
            rob       = RD;
            m_valid   = 0;
            m_illegal = 0;
        end else begin
            for (int i = 0; i < NS; i++) begin
                bit take;
                take = acc && ref_needs_station(op) && (ref_station(op) == i);
                if (take && !sf[i]) cred[i]--;
                else if (!take && sf[i] && cred[i] < SD) cred[i]++;
            end
            if (acc && ref_legal(op) && !rf) rob--;
            else if (!(acc && ref_legal(op)) && rf && rob < RD) rob++;
            m_illegal = acc && !ref_legal(op);
            if (acc && ref_legal(op)) begin
                m_valid  = 1;
                m_bundle = ref_bundle(op, rd);
            end else if (rdy_out) begin
                m_valid = 0;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.in_valid  = 0;
        bus.opcode    = 4'd0;
        bus.dest_reg  = 5'd0;
        bus.out_ready = 1;
        station_free  = '0;
        rob_free      = 0;
        flush         = 0;
    endtask

    task automatic do_flush();
        idle_inputs();
        flush = 1;
        tick();
        flush = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset_n = 0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %0b expected 0", bus.out_valid); end
        n_cmp++; if (illegal !== 1'b0) begin n_bad++; $display("FAIL reset_illegal: got %0b expected 0", illegal); end
        n_cmp++; if (station_full !== '0) begin n_bad++; $display("FAIL reset_station_full: got %0h expected 0", station_full); end
        n_cmp++; if (rob_full !== 1'b0) begin n_bad++; $display("FAIL reset_rob_full: got %0b expected 0", rob_full); end
        n_cmp++; if (dut_bundle() !== 18'h0) begin n_bad++; $display("FAIL reset_bundle: got %0h expected 0", dut_bundle()); end
        @(negedge clk);
        reset_n = 1;
    endtask

    task automatic test_r_type();
        bus.in_valid = 1; bus.opcode = 4'd1; bus.dest_reg = 5'd5; bus.out_ready = 1;
        #1;
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL r_ready: got %0b expected 1", bus.in_ready); end
        tick();
        bus.in_valid = 0;
        #1;
        n_cmp++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL r_out_valid: got %0b expected 1", bus.out_valid); end
        n_cmp++; if (dut_bundle() !== ref_bundle(4'd1, 5'd5)) begin n_bad++; $display("FAIL r_bundle: got %0h expected %0h", dut_bundle(), ref_bundle(4'd1, 5'd5)); end
        n_cmp++; if ({bus.alu_op, bus.use_imm, bus.reg_write, bus.rs_station} !== 6'b00_0_1_00) begin n_bad++; $display("FAIL r_fields: got %0b expected 000100", {bus.alu_op, bus.use_imm, bus.reg_write, bus.rs_station}); end
        tick();
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL r_pop: got %0b expected 0", bus.out_valid); end
        station_free = 4'b0001; rob_free = 1;
        tick();
        station_free = '0; rob_free = 0;
    endtask

    task automatic test_credit_exhaust();
        bus.in_valid = 1; bus.opcode = 4'd2; bus.out_ready = 1;
        for (int k = 0; k < 8; k++) begin
            bus.dest_reg = 5'($urandom);
            #1;
            n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL exhaust_ready_%0d: got %0b expected 1", k, bus.in_ready); end
            tick();
        end
        #1;
        n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL exhaust_ninth_ready: got %0b expected 0", bus.in_ready); end
        n_cmp++; if (station_full[0] !== 1'b1) begin n_bad++; $display("FAIL exhaust_full: got %0b expected 1", station_full[0]); end
        n_cmp++; if (dut_bundle() !== m_bundle) begin n_bad++; $display("FAIL exhaust_last_bundle: got %0h expected %0h", dut_bundle(), m_bundle); end
        station_free = 4'b0001;
        #1;
        n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL return_same_cycle_ready: got %0b expected 0", bus.in_ready); end
        tick();
        station_free = '0;
        #1;
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL return_next_cycle_ready: got %0b expected 1", bus.in_ready); end
        tick();
        bus.in_valid = 0;
        #1;
        n_cmp++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL return_accept_valid: got %0b expected 1", bus.out_valid); end
        tick();
    endtask

    task automatic test_store_branch();
        do_flush();
        bus.in_valid = 1; bus.opcode = 4'd3; bus.dest_reg = 5'd0;
        #1;
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL store_ready: got %0b expected 1", bus.in_ready); end
        tick();
        bus.opcode = 4'd4; bus.dest_reg = 5'd7;
        #1;
        n_cmp++; if ({bus.mem_write, bus.reg_write} !== 2'b10) begin n_bad++; $display("FAIL store_flags: got %0b expected 10", {bus.mem_write, bus.reg_write}); end
        n_cmp++; if (dut_bundle() !== ref_bundle(4'd3, 5'd0)) begin n_bad++; $display("FAIL store_bundle: got %0h expected %0h", dut_bundle(), ref_bundle(4'd3, 5'd0)); end
        tick();
        bus.in_valid = 0;
        #1;
        n_cmp++; if ({bus.branch, bus.reg_write} !== 2'b10) begin n_bad++; $display("FAIL branch_flags: got %0b expected 10", {bus.branch, bus.reg_write}); end
        n_cmp++; if (dut_bundle() !== ref_bundle(4'd4, 5'd7)) begin n_bad++; $display("FAIL branch_bundle: got %0h expected %0h", dut_bundle(), ref_bundle(4'd4, 5'd7)); end
        tick();
    endtask

    task automatic test_jal();
        do_flush();
        bus.in_valid = 1; bus.dest_reg = 5'd1;
        bus.opcode = 4'd4;
        repeat (8) tick();
        bus.opcode = 4'd2;
        repeat (7) tick();
        bus.opcode = 4'd6;
        #1;
        n_cmp++; if (station_full[1] !== 1'b1) begin n_bad++; $display("FAIL jal_branch_full: got %0b expected 1", station_full[1]); end
        n_cmp++; if (rob_full !== 1'b0) begin n_bad++; $display("FAIL jal_rob_before: got %0b expected 0", rob_full); end
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL jal_ready: got %0b expected 1", bus.in_ready); end
        tick();
        bus.in_valid = 0;
        #1;
        n_cmp++; if ({bus.out_valid, bus.is_jal, bus.station_request} !== 3'b110) begin n_bad++; $display("FAIL jal_flags: got %0b expected 110", {bus.out_valid, bus.is_jal, bus.station_request}); end
        n_cmp++; if (rob_full !== 1'b1) begin n_bad++; $display("FAIL jal_rob_after: got %0b expected 1", rob_full); end
        n_cmp++; if (dut_bundle() !== ref_bundle(4'd6, 5'd1)) begin n_bad++; $display("FAIL jal_bundle: got %0h expected %0h", dut_bundle(), ref_bundle(4'd6, 5'd1)); end
        tick();
    endtask

    task automatic test_backpressure();
        do_flush();
        bus.in_valid = 1; bus.opcode = 4'd2; bus.dest_reg = 5'd3; bus.out_ready = 0;
        tick();
        bus.opcode = 4'd1; bus.dest_reg = 5'd9;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL stall_ready_%0d: got %0b expected 0", k, bus.in_ready); end
            n_cmp++; if (dut_bundle() !== ref_bundle(4'd2, 5'd3) || bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL stall_hold_%0d: got %0h/%0b expected %0h/1", k, dut_bundle(), bus.out_valid, ref_bundle(4'd2, 5'd3)); end
            tick();
        end
        bus.out_ready = 1;
        #1;
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL release_ready: got %0b expected 1", bus.in_ready); end
        tick();
        bus.in_valid = 0;
        #1;
        n_cmp++; if (dut_bundle() !== ref_bundle(4'd1, 5'd9) || bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL release_bundle: got %0h/%0b expected %0h/1", dut_bundle(), bus.out_valid, ref_bundle(4'd1, 5'd9)); end
        tick();
    endtask

    task automatic test_illegal_flush();
        do_flush();
        bus.in_valid = 1; bus.opcode = 4'd2; bus.dest_reg = 5'd4;
        repeat (5) tick();
        bus.opcode = 4'd15;
        #1;
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL illegal_ready: got %0b expected 1", bus.in_ready); end
        tick();
        bus.in_valid = 0;
        #1;
        n_cmp++; if ({illegal, bus.out_valid} !== 2'b10) begin n_bad++; $display("FAIL illegal_pulse: got %0b expected 10", {illegal, bus.out_valid}); end
        n_cmp++; if ({rob_full, station_full} !== {1'b0, exp_full()}) begin n_bad++; $display("FAIL illegal_credits: got %0h expected %0h", {rob_full, station_full}, {1'b0, exp_full()}); end
        tick();
        n_cmp++; if (illegal !== 1'b0) begin n_bad++; $display("FAIL illegal_one_cycle: got %0b expected 0", illegal); end
        bus.in_valid = 1; bus.opcode = 4'd2; bus.out_ready = 0;
        tick();
        flush = 1; station_free = 4'b0001; rob_free = 1;
        #1;
        n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL flush_blocks: got %0b expected 0", bus.in_ready); end
        tick();
        flush = 0; station_free = '0; rob_free = 0; bus.in_valid = 0; bus.out_ready = 1;
        #1;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_out_valid: got %0b expected 0", bus.out_valid); end
        bus.in_valid = 1;
        for (int k = 0; k < 8; k++) begin
            #1;
            n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL flush_refill_%0d: got %0b expected 1", k, bus.in_ready); end
            tick();
        end
        #1;
        n_cmp++; if ({bus.in_ready, station_full[0]} !== 2'b01) begin n_bad++; $display("FAIL flush_depth: got %0b expected 01", {bus.in_ready, station_full[0]}); end
        bus.in_valid = 0;
        tick();
    endtask

    task automatic test_reset_midflight();
        do_flush();
        bus.in_valid = 1; bus.opcode = 4'd9; bus.dest_reg = 5'd2; bus.out_ready = 0;
        tick();
        bus.in_valid = 0;
        #1;
        n_cmp++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL midreset_held: got %0b expected 1", bus.out_valid); end
        #2;
        reset_n = 0;
        #1;
        n_cmp++; if ({bus.out_valid, dut_bundle()} !== 19'h0) begin n_bad++; $display("FAIL midreset_drop: got %0h expected 0", {bus.out_valid, dut_bundle()}); end
        model_reset();
        @(negedge clk);
        reset_n = 1;
        bus.out_ready = 1;
    endtask

    task automatic test_random();
        do_flush();
        for (int k = 0; k < 400; k++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.opcode    = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
            bus.dest_reg  = 5'($urandom);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NS; i++) station_free[i] = (cred[i] < SD) && ($urandom_range(0, 2) == 0);
            rob_free = (rob < RD) && ($urandom_range(0, 1) == 0);
            flush    = ($urandom_range(0, 40) == 0);
            #1;
            n_cmp++; if (bus.in_ready !== exp_ready()) begin n_bad++; $display("FAIL rnd_ready_%0d: got %0b expected %0b", k, bus.in_ready, exp_ready()); end
            n_cmp++; if ({bus.out_valid, illegal} !== {m_valid, m_illegal}) begin n_bad++; $display("FAIL rnd_valid_%0d: got %0b expected %0b", k, {bus.out_valid, illegal}, {m_valid, m_illegal}); end
            n_cmp++; if ({rob_full, station_full} !== {rob == 0, exp_full()}) begin n_bad++; $display("FAIL rnd_full_%0d: got %0h expected %0h", k, {rob_full, station_full}, {rob == 0, exp_full()}); end
            if (m_valid) begin
                n_cmp++; if (dut_bundle() !== m_bundle) begin n_bad++; $display("FAIL rnd_bundle_%0d: got %0h expected %0h", k, dut_bundle(), m_bundle); end
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_r_type();
        test_credit_exhaust();
        test_store_branch();
        test_jal();
        test_backpressure();
        test_illegal_flush();
        test_reset_midflight();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
